id_ex_pipe_reg: RTL

// - ID/EX pipeline register of the RV32I 5-stage core.
// - Captures decoded control, operands and instruction fields at the end of ID and presents them to EX.
// - ex_aluop/ex_funct3/ex_funct7 feed ALU_Control; the operands feed the ALU and the forwarding muxes.
// - Implements hold on stall and bubble insertion on flush (branch/jump redirect or load-use bubble).

---
 rtl/rv32_pkg.sv | 37 +++
 rtl/id_ex_pipe_reg.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline types: ALU-op encoding, the ID/EX payload struct and its bubble value.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_ALU = 2'b10
  } aluop_e;

  // aluop is kept as raw bits so the reserved 2'b11 code reaches EX untouched.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [1:0]        aluop;
    logic              alusrc;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic              memtoreg;
    logic              branch;
    logic              jump;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: holds on stall, writes an all-zero bubble on flush or an invalid ID slot.
// stall and flush are level controls sampled every posedge; there is no valid/ready handshake.
module id_ex_pipe_reg
  import rv32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [1:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              id_jump,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [1:0]        ex_aluop,
  output logic              ex_alusrc,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [15:0]       bubble_cnt
);

  id_ex_t      id_s;
  id_ex_t      ex_d, ex_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    id_s          = ID_EX_BUBBLE;
    id_s.valid    = id_valid;
    id_s.pc       = id_pc;
    id_s.rs1_data = id_rs1_data;
    id_s.rs2_data = id_rs2_data;
    id_s.imm      = id_imm;
    id_s.rs1      = id_rs1;
    id_s.rs2      = id_rs2;
    id_s.rd       = id_rd;
    id_s.funct3   = id_funct3;
    id_s.funct7   = id_funct7;
    id_s.aluop    = id_aluop;
    id_s.alusrc   = id_alusrc;
    id_s.memread  = id_memread;
    id_s.memwrite = id_memwrite;
    id_s.regwrite = id_regwrite;
    id_s.memtoreg = id_memtoreg;
    id_s.branch   = id_branch;
    id_s.jump     = id_jump;
  end

  // Flush beats stall; an invalid ID slot loads the same bubble but is not counted.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = ID_EX_BUBBLE;
    end else if (!stall) begin
      ex_d = id_valid ? id_s : ID_EX_BUBBLE;
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (flush && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7   = ex_q.funct7;
  assign ex_aluop    = ex_q.aluop;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_branch   = ex_q.branch;
  assign ex_jump     = ex_q.jump;
  assign bubble_cnt  = bubble_cnt_q;

endmodule
